irq_ctrl: RTL
=============

Name: irq_ctrl

Overview:
- Interrupt controller between the MMIO timers/external devices and CP0.
- Latches rising edges of up to NSRC interrupt sources into a pending register and applies a software mask.
- Selects the highest-priority source and runs a req/ack/EOI handshake with CP0, so exactly one source is in service at a time.
- Sits on the system bridge as a 4-word MMIO device, alongside Timer0/Timer1.

Parameters:
- NSRC, 6, number of interrupt sources (1..6); source 0 has the highest priority.
- IDW, 3, width of the source index; must satisfy 2^IDW >= NSRC.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- Addr  input  30 (bits 31:2)  word address from bridge; only Addr[3:2] decoded
- WE  input  1  register write strobe, already qualified by bridge select
- Din  input  32  write data
- Dout  output  32  read data, combinational from Addr[3:2]
- src_irq  input  NSRC  raw interrupt lines from devices (e.g. Timer IRQ)
- int_ack  input  1  one-cycle pulse from CP0 when the exception is taken
- int_req  output  1  interrupt request to CP0
- int_id  output  IDW  index of the requested or in-service source
- hw_int  output  6  pend & mask, zero-extended, for the CP0 Cause.IP view

Behaviour:
- Register map (Addr[3:2]):
  - 0 PEND: RO view of pend; writing 1 to a bit clears it (W1C).
  - 1 MASK: RW; only low NSRC bits are stored, upper bits read 0.
  - 2 STAT: RO {valid at bit 31, 0s, state at bits 9:8, int_id at IDW-1:0}.
  - 3 EOI: write of any value ends service; reads 0.
- Edge capture:
  - src_d is src_irq registered each cycle.
  - pend[i] is set when src_irq[i] & ~src_d[i].
  - Set beats any same-cycle clear (W1C or ack).
- State machine: IDLE=0, REQ=1, SERV=2.
  - IDLE: if (pend & mask) != 0, latch int_id = lowest set index and go to REQ the next cycle. int_req=0.
  - REQ: int_req=1 and int_id is held stable. If int_ack: clear pend[int_id] (unless re-set this cycle), set valid=1, go to SERV. Else if mask[int_id] or pend[int_id] drops (via MASK write or PEND W1C): withdraw to IDLE, with int_req=0 the next cycle. A higher-priority arrival does not preempt the request.
  - SERV: int_req=0, valid=1. An EOI write clears valid and goes to IDLE. New edges accumulate in pend; there is no nesting. int_ack is ignored.
  - int_ack in IDLE or SERV is ignored.
- Timing and bus:
  - Latency from source edge to int_req=1 is 2 cycles: capture, then IDLE→REQ.
  - EOI in SERV with pend & mask nonzero gives int_req again 2 cycles later.
  - WE and int_ack in the same cycle are both applied.
  - Reads are side-effect free; Dout is valid in the same cycle.
- Reset: pend=0, mask=0, src_d=0, state=IDLE, valid=0, int_id=0, int_req=0, hw_int=0. Reset mid-REQ/SERV drops int_req in the next cycle; src_d=0 means a source held high through reset produces one edge after reset release.

Optional Feature:
- Macro IRQ_LEVEL_EN.
- Defined: sources are level-sensitive.
  - pend <= src_irq every cycle and PEND writes are ignored.
  - Ack does not clear pend; the device must deassert its line, e.g. Timer ctrl write.
  - In REQ, a deasserted line withdraws the request as above.
- Undefined: rising-edge capture with W1C, as specified above.

Decomposition:
- Package irq_pkg:
  - state encodings IRQ_IDLE/IRQ_REQ/IRQ_SERV
  - register offsets REG_PEND=0, REG_MASK=1, REG_STAT=2, REG_EOI=3
  - STAT field positions
- Sub-module irq_prio_enc: combinational NSRC-to-{any, IDW index} lowest-index-first encoder, instantiated once.

Test Plan:
- Reset, then read all four registers → all 0, int_req=0, hw_int=0.
- MASK=0x03, pulse src_irq[1] at cycle t → pend=0x02 at t+1, int_req=1 and int_id=1 at t+2. int_ack → STAT=0x8000_0201, int_req=0, PEND=0. EOI write → STAT=0, state IDLE.
- MASK=0x3F, edges on src 4 and src 2 in the same cycle → int_id=2 first. Ack, EOI → int_req again 2 cycles later with int_id=4.
- MASK=0x01, edge on src 0, then MASK=0 while in REQ → int_req=0 the next cycle, state IDLE, PEND still 0x01.
- In REQ for src 3, same cycle: int_ack plus a new edge on src 3 → SERV with pend[3]=1. After EOI, re-request with int_id=3.
- With IRQ_LEVEL_EN: hold src 5 high with MASK=0x20, ack, EOI → int_req reasserts. Drop src 5 → pend[5]=0 the next cycle, and a PEND W1C write has no effect.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, register map, STAT layout.
// Level-sensitive source mode is selected with the IRQ_LEVEL_EN macro.
package irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_SERV = 2'd2
  } irq_state_e;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_EOI  = 2'd3;

  localparam int STAT_VALID_BIT = 31;
  localparam int STAT_STATE_LSB = 8;
  localparam int STAT_ID_LSB    = 0;

  function automatic logic [31:0] stat_word(input logic valid, input irq_state_e st,
                                            input logic [7:0] id);
    logic [31:0] w;
    w = '0;
    w[STAT_VALID_BIT]       = valid;
    w[STAT_STATE_LSB +: 2]  = st;
    w[STAT_ID_LSB +: 8]     = id;
    return w;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any request is set and
// the index of the highest-priority (lowest-numbered) one.
module irq_prio_enc #(
  parameter int NSRC = 6,
  parameter int IDW  = 3
) (
  input  logic [NSRC-1:0] req,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  always_comb begin
    any = |req;
    idx = '0;
    // Walk downwards so the lowest set index is the last one written.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) idx = IDW'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending/mask registers, priority select and req/ack/EOI
// handshake with CP0. Define IRQ_LEVEL_EN for level-sensitive sources.
import irq_pkg::*;

module irq_ctrl #(
  parameter int NSRC = 6,
  parameter int IDW  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:2]     Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  input  logic [NSRC-1:0] src_irq,
  input  logic            int_ack,
  output logic            int_req,
  output logic [IDW-1:0]  int_id,
  output logic [5:0]      hw_int
);

  // Handshake: int_req stays high with int_id stable until CP0 pulses int_ack
  // (request taken) or the selected source loses its mask/pending bit (withdrawn).
  // The FSM state is observable through the STAT register.

  logic [NSRC-1:0] pend, mask, pend_nxt, mask_nxt, active, id_bit;
  irq_state_e      state;
  logic            valid;
  logic [1:0]      reg_sel;
  logic            wr_mask, wr_eoi, ack_take, keep_req, any;
  logic [IDW-1:0]  top_id;

  assign reg_sel  = Addr[3:2];
  assign wr_mask  = WE && (reg_sel == REG_MASK);
  assign wr_eoi   = WE && (reg_sel == REG_EOI);
  assign ack_take = (state == IRQ_REQ) && int_ack;
  assign id_bit   = NSRC'(1) << int_id;
  assign mask_nxt = wr_mask ? Din[NSRC-1:0] : mask;

`ifdef IRQ_LEVEL_EN
  // Pending simply follows the lines; the device clears its own request.
  assign pend_nxt = src_irq;

  logic unused_bits;
  assign unused_bits = ^{Addr[31:4], Din[31:NSRC], ack_take};
`else
  logic [NSRC-1:0] src_d, clr;
  logic            wr_pend;

  assign wr_pend  = WE && (reg_sel == REG_PEND);
  assign clr      = (wr_pend ? Din[NSRC-1:0] : '0) | (ack_take ? id_bit : '0);
  // A fresh edge wins over any clear landing in the same cycle.
  assign pend_nxt = (pend & ~clr) | (src_irq & ~src_d);

  always_ff @(posedge clk) begin
    if (reset) src_d <= '0;
    else       src_d <= src_irq;
  end

  logic unused_bits;
  assign unused_bits = ^{Addr[31:4], Din[31:NSRC]};
`endif

  // Withdrawal looks at next-cycle values so a MASK/PEND write drops int_req at once.
  assign keep_req = |(id_bit & mask_nxt & pend_nxt);
  assign active   = pend & mask;
  assign hw_int   = 6'(active);

  irq_prio_enc #(.NSRC(NSRC), .IDW(IDW)) u_enc (
    .req (active),
    .any (any),
    .idx (top_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
      mask <= '0;
    end else begin
      pend <= pend_nxt;
      mask <= mask_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IRQ_IDLE;
      valid   <= 1'b0;
      int_id  <= '0;
      int_req <= 1'b0;
    end else begin
      case (state)
        IRQ_IDLE: begin
          if (any) begin
            int_id  <= top_id;
            int_req <= 1'b1;
            state   <= IRQ_REQ;
          end
        end
        IRQ_REQ: begin
          if (int_ack) begin
            int_req <= 1'b0;
            valid   <= 1'b1;
            state   <= IRQ_SERV;
          end else if (!keep_req) begin
            int_req <= 1'b0;
            int_id  <= '0;
            state   <= IRQ_IDLE;
          end
        end
        IRQ_SERV: begin
          if (wr_eoi) begin
            valid  <= 1'b0;
            int_id <= '0;
            state  <= IRQ_IDLE;
          end
        end
        default: begin
          int_req <= 1'b0;
          valid   <= 1'b0;
          int_id  <= '0;
          state   <= IRQ_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    Dout = '0;
    case (reg_sel)
      REG_PEND: Dout = 32'(pend);
      REG_MASK: Dout = 32'(mask);
      REG_STAT: Dout = stat_word(valid, state, 8'(int_id));
      default:  Dout = '0;
    endcase
  end

endmodule
